// File: rtl/rf_arb_pkg.sv
// Shared types for the register-file write-port arbiter.
package rf_arb_pkg;

  typedef logic [4:0]  reg_addr_t;
  typedef logic [31:0] word_t;

  typedef struct packed {
    reg_addr_t rd;
    word_t     data;
  } ll_entry_t;

  localparam reg_addr_t REG_ZERO = 5'd0;

endpackage

// File: rtl/rf_arb_fifo.sv
// In-order result FIFO for long-latency writebacks; pointers carry an extra
// wrap bit so full and empty are distinguishable without a counter.
module rf_arb_fifo
  import rf_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push,
  input  ll_entry_t din,
  input  logic      pop,
  output logic      full,
  output logic      empty,
  output ll_entry_t head
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned PW = AW + 1;

  logic [AW:0] wptr;
  logic [AW:0] rptr;
  ll_entry_t   mem [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);
    end
  end

  // Storage needs no reset; validity is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    if (push) mem[wptr[AW-1:0]] <= din;
  end

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign head  = mem[rptr[AW-1:0]];

endmodule

// File: rtl/rf_wb_arbiter.sv
// Shares the register-file write port between WB and buffered long-latency
// results, with a busy scoreboard and a starvation guard. Optional same-cycle
// long-latency bypass into an idle write port: define LL_BYPASS_EN.
module rf_wb_arbiter
  import rf_arb_pkg::*;
#(
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wb_we,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  input  logic        ll_valid,
  output logic        ll_ready,
  input  logic [4:0]  ll_rd,
  input  logic [31:0] ll_data,
  input  logic        issue_valid,
  input  logic [4:0]  issue_rd,
  output logic [31:0] busy,
  output logic        stall_wb,
  output logic        rf_we3,
  output logic [4:0]  rf_a3,
  output logic [31:0] rf_wd3
);

  localparam int unsigned CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] SMAX = CW'(STARVE_MAX);

  logic          fifo_full;
  logic          fifo_empty;
  ll_entry_t     head;
  ll_entry_t     ll_entry;
  logic          push;
  logic          pop;
  logic          sel_fifo;
  logic          sel_wb;
  logic          bypass;
  logic          wr;
  logic [CW-1:0] starve_q;
  logic [CW-1:0] starve_d;
  logic [CW-1:0] starve_inc;
  logic          stall_d;
  logic [31:0]   busy_d;

  assign ll_entry = '{rd: ll_rd, data: ll_data};
  assign ll_ready = rst_n && !fifo_full;

  rf_arb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (ll_entry),
    .pop   (pop),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (head)
  );

  // Write-port selection: a forced stall hands the port to the FIFO head.
  always_comb begin
    bypass = 1'b0;
`ifdef LL_BYPASS_EN
    bypass = fifo_empty && !wb_we && !stall_wb && ll_valid;
`endif
    sel_fifo = !fifo_empty && (stall_wb || !wb_we);
    sel_wb   = !sel_fifo && wb_we;
    pop      = sel_fifo;
    push     = ll_valid && ll_ready && !bypass;
    wr       = 1'b0;
    rf_a3    = REG_ZERO;
    rf_wd3   = '0;
    if (sel_fifo) begin
      wr     = 1'b1;
      rf_a3  = head.rd;
      rf_wd3 = head.data;
    end else if (sel_wb) begin
      wr     = 1'b1;
      rf_a3  = wb_rd;
      rf_wd3 = wb_data;
    end else if (bypass) begin
      wr     = 1'b1;
      rf_a3  = ll_rd;
      rf_wd3 = ll_data;
    end
    rf_we3 = wr && (rf_a3 != REG_ZERO);
  end

  // Starvation counter and scoreboard next state.
  always_comb begin
    starve_d   = '0;
    stall_d    = 1'b0;
    starve_inc = starve_q + CW'(1);
    if (!fifo_empty && sel_wb) begin
      if (starve_inc == SMAX) stall_d  = 1'b1;
      else                    starve_d = starve_inc;
    end
    busy_d = busy;
    if (pop)    busy_d[head.rd] = 1'b0;
    if (bypass) busy_d[ll_rd]   = 1'b0;
    if (issue_valid && issue_rd != REG_ZERO) busy_d[issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy     <= '0;
      starve_q <= '0;
      stall_wb <= 1'b0;
    end else begin
      busy     <= busy_d;
      starve_q <= starve_d;
      stall_wb <= stall_d;
    end
  end

  // Neighbour protocol obligations.
  a_issue_not_busy: assert property (@(posedge clk) disable iff (!rst_n)
    (issue_valid && issue_rd != REG_ZERO) |-> !busy[issue_rd]);
  a_wb_not_busy: assert property (@(posedge clk) disable iff (!rst_n)
    wb_we |-> !busy[wb_rd]);
  a_ll_is_busy: assert property (@(posedge clk) disable iff (!rst_n)
    ll_valid |-> busy[ll_rd]);

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed self-checking bench for rf_wb_arbiter (DEPTH=2, STARVE_MAX=4).
module tb_rf_wb_arbiter;

  logic        clk;
  logic        rst_n;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        ll_valid;
  logic        ll_ready;
  logic [4:0]  ll_rd;
  logic [31:0] ll_data;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic [31:0] busy;
  logic        stall_wb;
  logic        rf_we3;
  logic [4:0]  rf_a3;
  logic [31:0] rf_wd3;

  int n_cmp = 0;
  int n_err = 0;

`ifdef LL_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  rf_wb_arbiter #(.DEPTH(2), .STARVE_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .ll_valid(ll_valid), .ll_ready(ll_ready), .ll_rd(ll_rd), .ll_data(ll_data),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .busy(busy),
    .stall_wb(stall_wb), .rf_we3(rf_we3), .rf_a3(rf_a3), .rf_wd3(rf_wd3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    wb_we = 1'b0; wb_rd = 5'd0; wb_data = 32'd0;
    ll_valid = 1'b0; ll_rd = 5'd0; ll_data = 32'd0;
    issue_valid = 1'b0; issue_rd = 5'd0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    step(); settle();
    n_cmp++; if (rf_we3 !== 1'b0) begin n_err++; $display("FAIL rst_we3: got %b want 0", rf_we3); end
    n_cmp++; if (busy !== 32'd0) begin n_err++; $display("FAIL rst_busy: got %h want 0", busy); end
    n_cmp++; if (ll_ready !== 1'b0) begin n_err++; $display("FAIL rst_ready: got %b want 0", ll_ready); end
    n_cmp++; if (stall_wb !== 1'b0) begin n_err++; $display("FAIL rst_stall: got %b want 0", stall_wb); end
    step(); settle();
    n_cmp++; if (ll_ready !== 1'b0) begin n_err++; $display("FAIL rst_ready2: got %b want 0", ll_ready); end
    step();
    rst_n = 1'b1;
    step(); settle();
    n_cmp++; if (ll_ready !== 1'b1) begin n_err++; $display("FAIL rel_ready: got %b want 1", ll_ready); end
    n_cmp++; if (rf_we3 !== 1'b0) begin n_err++; $display("FAIL rel_we3: got %b want 0", rf_we3); end
  endtask

  task automatic test_lone();
    issue_valid = 1'b1; issue_rd = 5'd5;
    step();
    issue_valid = 1'b0;
    settle();
    n_cmp++; if (busy !== 32'h0000_0020) begin n_err++; $display("FAIL lone_busy_c1: got %h want 00000020", busy); end
    step(); settle();
    n_cmp++; if (busy[5] !== 1'b1) begin n_err++; $display("FAIL lone_busy_c2: got %b want 1", busy[5]); end
    step();
    ll_valid = 1'b1; ll_rd = 5'd5; ll_data = 32'hDEAD_BEEF;
    settle();
    n_cmp++; if (rf_we3 !== BYP) begin n_err++; $display("FAIL lone_we3_c3: got %b want %b", rf_we3, BYP); end
    step();
    ll_valid = 1'b0;
    settle();
    n_cmp++; if (rf_we3 !== !BYP) begin n_err++; $display("FAIL lone_we3_c4: got %b want %b", rf_we3, !BYP); end
    if (!BYP) begin
      n_cmp++; if (rf_a3 !== 5'd5) begin n_err++; $display("FAIL lone_a3: got %0d want 5", rf_a3); end
      n_cmp++; if (rf_wd3 !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL lone_wd3: got %h want deadbeef", rf_wd3); end
      n_cmp++; if (busy[5] !== 1'b1) begin n_err++; $display("FAIL lone_busy_c4: got %b want 1", busy[5]); end
    end
    step(); settle();
    n_cmp++; if (busy !== 32'd0) begin n_err++; $display("FAIL lone_busy_c5: got %h want 0", busy); end
    n_cmp++; if (rf_we3 !== 1'b0) begin n_err++; $display("FAIL lone_we3_c5: got %b want 0", rf_we3); end
  endtask

  task automatic test_starve();
    issue_valid = 1'b1; issue_rd = 5'd7;
    step();
    issue_valid = 1'b0;
    wb_we = 1'b1; wb_rd = 5'd1; wb_data = 32'h1000;
    ll_valid = 1'b1; ll_rd = 5'd7; ll_data = 32'h77;
    settle();
    n_cmp++; if (rf_a3 !== 5'd1 || rf_we3 !== 1'b1) begin n_err++; $display("FAIL starve_enq: got we=%b a3=%0d want we=1 a3=1", rf_we3, rf_a3); end
    step();
    ll_valid = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      wb_data = 32'h1000 + 32'(i);
      settle();
      n_cmp++; if (stall_wb !== 1'b0) begin n_err++; $display("FAIL starve_nostall%0d: got %b want 0", i, stall_wb); end
      n_cmp++; if (rf_a3 !== 5'd1 || rf_wd3 !== 32'h1000 + 32'(i)) begin
        n_err++; $display("FAIL starve_wb%0d: got a3=%0d wd=%h want a3=1 wd=%h", i, rf_a3, rf_wd3, 32'h1000 + 32'(i)); end
      step();
    end
    settle();
    n_cmp++; if (stall_wb !== 1'b1) begin n_err++; $display("FAIL starve_stall: got %b want 1", stall_wb); end
    n_cmp++; if (rf_we3 !== 1'b1 || rf_a3 !== 5'd7 || rf_wd3 !== 32'h77) begin
      n_err++; $display("FAIL starve_head: got we=%b a3=%0d wd=%h want we=1 a3=7 wd=77", rf_we3, rf_a3, rf_wd3); end
    step(); settle();
    n_cmp++; if (stall_wb !== 1'b0 || rf_a3 !== 5'd1) begin n_err++; $display("FAIL starve_resume: got stall=%b a3=%0d want stall=0 a3=1", stall_wb, rf_a3); end
    n_cmp++; if (busy !== 32'd0) begin n_err++; $display("FAIL starve_busy: got %h want 0", busy); end
    idle_inputs();
    step();
  endtask

  task automatic test_full();
    for (int r = 10; r <= 12; r++) begin
      issue_valid = 1'b1; issue_rd = 5'(r);
      step();
    end
    issue_valid = 1'b0;
    wb_we = 1'b1; wb_rd = 5'd2; wb_data = 32'h2000;
    ll_valid = 1'b1; ll_rd = 5'd10; ll_data = 32'hA0;
    settle();
    n_cmp++; if (ll_ready !== 1'b1) begin n_err++; $display("FAIL full_rdyA: got %b want 1", ll_ready); end
    step();
    ll_rd = 5'd11; ll_data = 32'hB0;
    settle();
    n_cmp++; if (ll_ready !== 1'b1) begin n_err++; $display("FAIL full_rdyB: got %b want 1", ll_ready); end
    step();
    ll_rd = 5'd12; ll_data = 32'hC0;
    settle();
    n_cmp++; if (ll_ready !== 1'b0 || rf_a3 !== 5'd2) begin n_err++; $display("FAIL full_rdyC: got rdy=%b a3=%0d want rdy=0 a3=2", ll_ready, rf_a3); end
    step(); settle();
    n_cmp++; if (ll_ready !== 1'b0) begin n_err++; $display("FAIL full_rdyD: got %b want 0", ll_ready); end
    step(); settle();
    n_cmp++; if (ll_ready !== 1'b0 || stall_wb !== 1'b0) begin n_err++; $display("FAIL full_E: got rdy=%b stall=%b want 0 0", ll_ready, stall_wb); end
    step(); settle();
    n_cmp++; if (stall_wb !== 1'b1 || rf_a3 !== 5'd10 || rf_wd3 !== 32'hA0 || ll_ready !== 1'b0) begin
      n_err++; $display("FAIL full_F: got stall=%b a3=%0d wd=%h rdy=%b want 1 10 a0 0", stall_wb, rf_a3, rf_wd3, ll_ready); end
    step(); settle();
    n_cmp++; if (ll_ready !== 1'b1 || stall_wb !== 1'b0 || rf_a3 !== 5'd2) begin
      n_err++; $display("FAIL full_G: got rdy=%b stall=%b a3=%0d want 1 0 2", ll_ready, stall_wb, rf_a3); end
    n_cmp++; if (busy !== 32'h0000_1800) begin n_err++; $display("FAIL full_busyG: got %h want 00001800", busy); end
    step();
    ll_valid = 1'b0; wb_we = 1'b0;
    settle();
    n_cmp++; if (ll_ready !== 1'b0 || rf_a3 !== 5'd11 || rf_wd3 !== 32'hB0) begin
      n_err++; $display("FAIL full_H: got rdy=%b a3=%0d wd=%h want 0 11 b0", ll_ready, rf_a3, rf_wd3); end
    step(); settle();
    n_cmp++; if (ll_ready !== 1'b1 || rf_a3 !== 5'd12 || rf_wd3 !== 32'hC0) begin
      n_err++; $display("FAIL full_I: got rdy=%b a3=%0d wd=%h want 1 12 c0", ll_ready, rf_a3, rf_wd3); end
    step(); settle();
    n_cmp++; if (rf_we3 !== 1'b0 || busy !== 32'd0) begin n_err++; $display("FAIL full_J: got we=%b busy=%h want 0 0", rf_we3, busy); end
    idle_inputs();
  endtask

  task automatic test_x0();
    wb_we = 1'b1; wb_rd = 5'd0; wb_data = 32'h1234;
    issue_valid = 1'b1; issue_rd = 5'd0;
    settle();
    n_cmp++; if (rf_we3 !== 1'b0) begin n_err++; $display("FAIL x0_we3: got %b want 0", rf_we3); end
    step();
    idle_inputs();
    settle();
    n_cmp++; if (busy !== 32'd0) begin n_err++; $display("FAIL x0_busy: got %h want 0", busy); end
    step();
  endtask

  task automatic test_reset_mid();
    issue_valid = 1'b1; issue_rd = 5'd9;
    step();
    issue_valid = 1'b0;
    wb_we = 1'b1; wb_rd = 5'd1; wb_data = 32'h3000;
    ll_valid = 1'b1; ll_rd = 5'd9; ll_data = 32'h99;
    step();
    ll_valid = 1'b0;
    rst_n = 1'b0;
    settle();
    n_cmp++; if (busy !== 32'h0000_0200) begin n_err++; $display("FAIL mid_busy_pre: got %h want 00000200", busy); end
    step();
    rst_n = 1'b1;
    idle_inputs();
    settle();
    n_cmp++; if (busy !== 32'd0 || rf_we3 !== 1'b0) begin n_err++; $display("FAIL mid_cleared: got busy=%h we=%b want 0 0", busy, rf_we3); end
    step();
  endtask

`ifdef LL_BYPASS_EN
  task automatic test_bypass();
    issue_valid = 1'b1; issue_rd = 5'd3;
    step();
    issue_valid = 1'b0;
    ll_valid = 1'b1; ll_rd = 5'd3; ll_data = 32'h55;
    settle();
    n_cmp++; if (rf_we3 !== 1'b1 || rf_a3 !== 5'd3 || rf_wd3 !== 32'h55) begin
      n_err++; $display("FAIL byp_write: got we=%b a3=%0d wd=%h want 1 3 55", rf_we3, rf_a3, rf_wd3); end
    step();
    ll_valid = 1'b0;
    settle();
    n_cmp++; if (rf_we3 !== 1'b0 || busy !== 32'd0) begin n_err++; $display("FAIL byp_empty: got we=%b busy=%h want 0 0", rf_we3, busy); end
    step();
  endtask
`endif

  initial begin
    test_reset();
    test_lone();
    test_starve();
    test_full();
    test_x0();
    test_reset_mid();
`ifdef LL_BYPASS_EN
    test_bypass();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
